// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side definitions: FSM encoding, PC step and the default reset address.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INC   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; storage is not reset, only pointers and count.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A flush or reset cancels any push/pop presented in the same cycle.
  assign do_push = rst && !flush && push && !full;
  assign do_pop  = rst && !flush && pop && !empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps one imem read in flight
// and buffers returned words with their PC for decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(fetch_queue_pkg::RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0]   req_pc_q, req_pc_d;
  logic               push;
  logic               pop;
  logic               space;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [2*WIDTH-1:0] fifo_rdata;

  // Requests only issue from IDLE, so the slot for the in-flight word is
  // already accounted for by checking occupancy here.
  assign space = (fifo_count < CW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    imem_req   = 1'b0;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        imem_req = rst && space && !redirect_valid;
        if (imem_req) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + WIDTH'(PC_INC);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push    = !redirect_valid;
          state_d = IDLE;
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

  assign pop = out_valid && out_ready && !redirect_valid;

  sync_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({req_pc_q, imem_rdata}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) push |-> !fifo_full);

  assign imem_addr = fetch_pc_q;
  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_rdata[2*WIDTH-1:WIDTH];
  assign out_instr = fifo_rdata[WIDTH-1:0];
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: imem responder, scoreboard of expected in-order fetch
// streams restarted at every reset/redirect, directed scenarios plus random traffic.
module tb_fetch_queue;

  localparam int          W   = 32;
  localparam int          D   = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;

  fetch_queue #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [31:0] exp_req_pc;
  logic [31:0] req_log[$];
  int          req_cnt = 0;
  int          pop_cnt = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A new fetch stream begins at every reset or redirect: pc, pc+4, ... in order.
  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      exp_t e;
      e.pc    = pc + 32'(4 * i);
      e.instr = imem_word(e.pc);
      exp_q.push_back(e);
    end
    exp_req_pc = pc;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    imem_rvalid = pend && (cyc == pend_due);
    imem_rdata  = imem_rvalid ? imem_word(pend_addr) : 32'h0BAD_F00D;
  end

  // Monitor: sees what the coming edge will do and checks it against the model.
  always @(negedge clk) begin
    if (imem_rvalid) pend = 1'b0;
    if (rst) begin
      if (imem_req) begin
        check32("one_outstanding", {31'd0, pend}, 32'd0);
        check32("no_req_on_redirect", {31'd0, redirect_valid}, 32'd0);
        check32("req_addr", imem_addr, exp_req_pc);
        exp_req_pc = exp_req_pc + 32'd4;
        req_log.push_back(imem_addr);
        req_cnt++;
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_due  = cyc + $urandom_range(lat_max, lat_min);
      end
      if (!redirect_valid && out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check32("pop_unexpected", out_pc, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check32("out_pc", out_pc, e.pc);
          check32("out_instr", out_instr, e.instr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    model_restart(pc);
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input int limit);
    int n;
    n = 0;
    while (!imem_req && n < limit) begin
      tick();
      n++;
    end
    if (!imem_req) check32("wait_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_log(input int size, input int limit);
    int n;
    n = 0;
    while (req_log.size() < size && n < limit) begin
      tick();
      n++;
    end
    if (req_log.size() < size) check32("wait_log_timeout", 32'(req_log.size()), 32'(size));
  endtask

  initial begin
    int c0, p0, r0, rl, n;
    bit head_moved;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    model_restart(RPC);
    tick(); tick();
    check32("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_imem_req", {31'd0, imem_req}, 32'd0);

    // Free run, one-cycle memory, decode always ready.
    out_ready = 1'b1; lat_min = 1; lat_max = 1;
    rst = 1'b1;
    c0 = cyc;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    check32("first_valid_latency", 32'(cyc - c0), 32'd2);
    p0 = pop_cnt;
    repeat (30) tick();
    checks++;
    if ((pop_cnt - p0) < 14 || (pop_cnt - p0) > 16) begin
      errors++;
      $display("FAIL throughput: got %0d pops in 30 cycles expected 14..16", pop_cnt - p0);
    end

    // Backpressure from a fresh reset: FIFO fills to DEPTH and holds its head.
    out_ready = 1'b0;
    rst = 1'b0; model_restart(RPC); tick(); rst = 1'b1;
    r0 = req_cnt;
    head_moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 8 && (out_pc !== RPC || !out_valid)) head_moved = 1'b1;
    end
    check32("bp_req_count", 32'(req_cnt - r0), 32'(D));
    check32("bp_req_low", {31'd0, imem_req}, 32'd0);
    check32("bp_head_stable", {31'd0, head_moved}, 32'd0);
    check32("bp_head_pc", out_pc, RPC);
    p0 = pop_cnt;
    out_ready = 1'b1;
    repeat (12) tick();
    checks++;
    if (pop_cnt - p0 < D) begin
      errors++;
      $display("FAIL bp_drain: got %0d pops expected at least %0d", pop_cnt - p0, D);
    end

    // Redirect while a request is outstanding; its data returns 3 cycles later.
    lat_min = 3; lat_max = 3;
    wait_req(20);
    tick();
    check32("wait_busy", {31'd0, busy}, 32'd1);
    rl = req_log.size();
    lat_min = 1; lat_max = 1;
    redirect_to(32'h40);
    check32("drop_busy", {31'd0, busy}, 32'd1);
    wait_log(rl + 1, 20);
    if (req_log.size() > rl) check32("redir_addr", req_log[rl], 32'h40);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check32("redir_out_pc", out_pc, 32'h40);

    // Redirect coinciding with rvalid and a pop while two entries are queued.
    out_ready = 1'b0;
    redirect_to(32'h200);
    n = 0;
    while (!(imem_rvalid && pend_addr == 32'h208) && n < 30) begin tick(); n++; end
    check32("same_cycle_two_queued", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    redirect_to(32'h300);
    check32("same_cycle_empty", {31'd0, out_valid}, 32'd0);
    check32("same_cycle_restart", imem_addr, 32'h300);

    // PC wrap at the top of the address space.
    rl = req_log.size();
    redirect_to(32'hFFFF_FFFC);
    wait_log(rl + 2, 30);
    if (req_log.size() >= rl + 2) begin
      check32("wrap_addr0", req_log[rl], 32'hFFFF_FFFC);
      check32("wrap_addr1", req_log[rl+1], 32'h0000_0000);
    end

    // Reset while WAIT, with the stale response landing right after reset.
    redirect_to(32'h100);
    lat_min = 2; lat_max = 2;
    wait_req(20);
    tick();
    rst = 1'b0;
    model_restart(RPC);
    rl = req_log.size();
    tick();
    rst = 1'b1;
    check32("rst_wait_valid0", {31'd0, out_valid}, 32'd0);
    tick();
    check32("rst_wait_valid1", {31'd0, out_valid}, 32'd0);
    wait_log(rl + 1, 20);
    if (req_log.size() > rl) check32("rst_first_addr", req_log[rl], RPC);
    repeat (10) tick();

    // Random traffic: random ready, latency and redirect targets.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0) redirect_to(32'hFFFF_FFF0);
        else redirect_to($urandom() & 32'hFFFF_FFFC);
      end else begin
        tick();
      end
    end
    out_ready = 1'b1;
    repeat (20) tick();
    checks++;
    if (pop_cnt < 100) begin
      errors++;
      $display("FAIL total_pops: got %0d expected at least 100", pop_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
